// File: rtl/imm_narrow_if.sv
// Stream bundle for the immediate-narrowing stage: input stream, output stream
// and the overflow counter side-band.
interface imm_narrow_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 14,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;
    logic [CNT_W-1:0] ovf_count;
    logic             ovf_clr;

    modport master (
        output in_valid, in_data, out_ready, ovf_clr,
        input  in_ready, out_valid, out_data, out_ovf, ovf_count
    );

    modport slave (
        input  in_valid, in_data, out_ready, ovf_clr,
        output in_ready, out_valid, out_data, out_ovf, ovf_count
    );
endinterface

// File: rtl/imm_narrow.sv
// Packs 16-bit signed values into the 14-bit signed immediate field with
// range check, saturate/truncate, overflow counting and a 2-entry output buffer.
//
// state   | meaning
// S_EMPTY | no entry buffered, out_valid=0
// S_ONE   | head entry valid
// S_FULL  | head and tail valid, in_ready=0
module imm_narrow #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 14,
    parameter int SAT_EN = 1,
    parameter int CNT_W  = 8
) (
    input  logic         clk,
    input  logic         rst,
    imm_narrow_if.slave  bus
);
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [OUT_W-1:0]   r_head_data;
    logic               r_head_ovf;
    logic [OUT_W-1:0]   r_tail_data;
    logic               r_tail_ovf;
    logic [CNT_W-1:0]   r_ovf_count;

    logic [IN_W-OUT_W:0] w_top;
    logic               w_fits;
    logic [OUT_W-1:0]   w_conv_data;
    logic               w_conv_ovf;
    logic               w_push;
    logic               w_pop;
    logic               w_ld_head_in;
    logic               w_ld_head_tail;
    logic               w_ld_tail;

    // Value fits when every bit from the MSB down to the target sign bit agrees.
    assign w_top  = bus.in_data[IN_W-1:OUT_W-1];
    assign w_fits = (&w_top) | ~(|w_top);

    always_comb begin
        w_conv_ovf  = ~w_fits;
        w_conv_data = bus.in_data[OUT_W-1:0];
        if (!w_fits && SAT_EN != 0) begin
            w_conv_data = bus.in_data[IN_W-1] ? SAT_NEG : SAT_POS;
        end
    end

    assign bus.in_ready  = (r_state != S_FULL);
    assign bus.out_valid = (r_state != S_EMPTY);
    assign bus.out_data  = r_head_data;
    assign bus.out_ovf   = r_head_ovf;
    assign bus.ovf_count = r_ovf_count;

    assign w_push = bus.in_valid && bus.in_ready;
    assign w_pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_ld_head_in   = 1'b0;
        w_ld_head_tail = 1'b0;
        w_ld_tail      = 1'b0;
        unique case (r_state)
            S_EMPTY: begin
                if (w_push) begin
                    w_state_nxt  = S_ONE;
                    w_ld_head_in = 1'b1;
                end
            end
            S_ONE: begin
                if (w_push && w_pop) begin
                    w_ld_head_in = 1'b1;
                end else if (w_push) begin
                    w_state_nxt = S_FULL;
                    w_ld_tail   = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_pop) begin
                    w_state_nxt    = S_ONE;
                    w_ld_head_tail = 1'b1;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_data <= '0;
            r_head_ovf  <= 1'b0;
            r_tail_data <= '0;
            r_tail_ovf  <= 1'b0;
        end else begin
            if (w_ld_head_in) begin
                r_head_data <= w_conv_data;
                r_head_ovf  <= w_conv_ovf;
            end else if (w_ld_head_tail) begin
                r_head_data <= r_tail_data;
                r_head_ovf  <= r_tail_ovf;
            end
            if (w_ld_tail) begin
                r_tail_data <= w_conv_data;
                r_tail_ovf  <= w_conv_ovf;
            end
        end
    end

    // Clear wins over a same-cycle overflow event; that event is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_count <= '0;
        end else if (bus.ovf_clr) begin
            r_ovf_count <= '0;
        end else if (w_push && w_conv_ovf && r_ovf_count != CNT_MAX) begin
            r_ovf_count <= r_ovf_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_imm_narrow.sv
// Randomized and directed bench for imm_narrow; a saturating and a truncating
// instance run side by side against a queue-based reference model.
module tb_imm_narrow;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_d;
    logic [15:0] in_data_d;
    logic        out_ready_d;
    logic        ovf_clr_d;

    int n_vec = 0;
    int n_err = 0;

    logic [14:0] q_s[$];
    logic [14:0] q_t[$];
    logic [14:0] disp_s;
    logic [14:0] disp_t;
    int          m_cnt;
    bit          acc;

    always #5 clk = ~clk;

    imm_narrow_if #(.IN_W(16), .OUT_W(14), .CNT_W(8)) s_if ();
    imm_narrow_if #(.IN_W(16), .OUT_W(14), .CNT_W(8)) t_if ();

    assign s_if.in_valid  = in_valid_d;
    assign s_if.in_data   = in_data_d;
    assign s_if.out_ready = out_ready_d;
    assign s_if.ovf_clr   = ovf_clr_d;
    assign t_if.in_valid  = in_valid_d;
    assign t_if.in_data   = in_data_d;
    assign t_if.out_ready = out_ready_d;
    assign t_if.ovf_clr   = ovf_clr_d;

    imm_narrow #(.IN_W(16), .OUT_W(14), .SAT_EN(1), .CNT_W(8)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (s_if.slave)
    );

    imm_narrow #(.IN_W(16), .OUT_W(14), .SAT_EN(0), .CNT_W(8)) u_trn (
        .clk (clk),
        .rst (rst),
        .bus (t_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: {ovf, data} from signed arithmetic on the value's numeric range.
    function automatic logic [14:0] ref_conv(input logic [15:0] d, input bit sat);
        int  v;
        bit  ovf;
        v   = int'($signed(d));
        ovf = (v > 8191) || (v < -8192);
        if (ovf && sat) v = (v > 0) ? 8191 : -8192;
        return {ovf, v[13:0]};
    endfunction

    task automatic cycle();
        bit m_rdy;
        bit m_vld;
        bit pop;
        bit push;
        @(negedge clk);
        m_rdy = (q_s.size() != 2);
        m_vld = (q_s.size() != 0);
        chk("in_ready_s",  32'(s_if.in_ready),  32'(m_rdy));
        chk("in_ready_t",  32'(t_if.in_ready),  32'(m_rdy));
        chk("out_valid_s", 32'(s_if.out_valid), 32'(m_vld));
        chk("out_valid_t", 32'(t_if.out_valid), 32'(m_vld));
        chk("out_data_s",  32'(s_if.out_data),  32'(disp_s[13:0]));
        chk("out_ovf_s",   32'(s_if.out_ovf),   32'(disp_s[14]));
        chk("out_data_t",  32'(t_if.out_data),  32'(disp_t[13:0]));
        chk("out_ovf_t",   32'(t_if.out_ovf),   32'(disp_t[14]));
        chk("ovf_count_s", 32'(s_if.ovf_count), 32'(m_cnt));
        chk("ovf_count_t", 32'(t_if.ovf_count), 32'(m_cnt));
        acc = 1'b0;
        if (rst) begin
            q_s.delete();
            q_t.delete();
            disp_s = '0;
            disp_t = '0;
            m_cnt  = 0;
        end else begin
            pop  = m_vld && out_ready_d;
            push = in_valid_d && m_rdy;
            if (pop) begin
                void'(q_s.pop_front());
                void'(q_t.pop_front());
            end
            if (push) begin
                q_s.push_back(ref_conv(in_data_d, 1'b1));
                q_t.push_back(ref_conv(in_data_d, 1'b0));
            end
            acc = push;
            if (ovf_clr_d) m_cnt = 0;
            else if (push && ref_conv(in_data_d, 1'b1) >= 15'h4000 && m_cnt != 255) m_cnt++;
            if (q_s.size() > 0) begin
                disp_s = q_s[0];
                disp_t = q_t[0];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        int n;
        n = 0;
        in_valid_d = 1'b1;
        in_data_d  = d;
        acc        = 1'b0;
        while (!acc && n < 200) begin
            cycle();
            n++;
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: value %h not accepted within %0d cycles", d, n);
        end
        in_valid_d = 1'b0;
    endtask

    initial begin
        logic [15:0] bnd[6];
        logic [15:0] d;
        int          v;
        int          got;
        int          n;

        bnd = '{16'h1FFF, 16'h2000, 16'hE000, 16'hDFFF, 16'h7FFF, 16'h8000};
        rst = 1'b1;
        in_valid_d = 1'b0;
        in_data_d  = '0;
        out_ready_d = 1'b0;
        ovf_clr_d  = 1'b0;
        disp_s = '0;
        disp_t = '0;
        m_cnt  = 0;
        @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;
        cycle();

        // In-range stream, one-cycle latency.
        out_ready_d = 1'b1;
        send(16'h0005);
        chk("lat_valid", 32'(s_if.out_valid), 32'd1);
        chk("lat_data",  32'(s_if.out_data),  32'h0005);
        send(16'hFFFB);
        send(16'h1FFF);
        send(16'hE000);
        repeat (3) cycle();
        chk("cnt_inrange", 32'(s_if.ovf_count), 32'd0);

        // Out-of-range: saturate vs truncate.
        send(16'h2000);
        chk("sat_2000", 32'(s_if.out_data), 32'h1FFF);
        chk("trn_2000", 32'(t_if.out_data), 32'h2000);
        chk("trn_2000_ovf", 32'(t_if.out_ovf), 32'd1);
        send(16'h7FFF);
        send(16'hDFFF);
        send(16'h8000);
        chk("sat_8000", 32'(s_if.out_data), 32'h2000);
        repeat (3) cycle();
        chk("cnt_four", 32'(s_if.ovf_count), 32'd4);

        // Backpressure: third value must wait upstream.
        out_ready_d = 1'b0;
        send(16'h0011);
        send(16'h0022);
        in_valid_d = 1'b1;
        in_data_d  = 16'h0033;
        repeat (3) cycle();
        out_ready_d = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            cycle();
            n++;
        end
        in_valid_d = 1'b0;
        repeat (4) cycle();

        // Counter saturation, then clear racing an overflow accept.
        for (int i = 0; i < 300; i++) send((i % 2 == 0) ? 16'h4000 : 16'h9000);
        repeat (2) cycle();
        chk("cnt_sat", 32'(s_if.ovf_count), 32'd255);
        ovf_clr_d = 1'b1;
        send(16'h4000);
        ovf_clr_d = 1'b0;
        chk("cnt_clr", 32'(s_if.ovf_count), 32'd0);
        repeat (3) cycle();

        // Reset while FULL with an accept offered.
        out_ready_d = 1'b0;
        send(16'h0101);
        send(16'h0202);
        in_valid_d = 1'b1;
        in_data_d  = 16'h0303;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        in_valid_d = 1'b0;
        chk("rst_out_valid", 32'(s_if.out_valid), 32'd0);
        chk("rst_in_ready",  32'(s_if.in_ready),  32'd1);
        chk("rst_count",     32'(s_if.ovf_count), 32'd0);
        repeat (2) cycle();

        // Random soak.
        got = 0;
        n = 0;
        while (got < 10000 && n < 40000) begin
            v = int'($urandom_range(0, 3));
            if (v == 0) d = 16'($urandom());
            else if (v == 1) d = bnd[$urandom_range(0, 5)];
            else begin
                v = int'($urandom_range(0, 16383)) - 8192;
                d = v[15:0];
            end
            in_valid_d  = ($urandom_range(0, 3) != 0);
            in_data_d   = d;
            out_ready_d = ($urandom_range(0, 2) != 0);
            ovf_clr_d   = ($urandom_range(0, 49) == 0);
            cycle();
            if (acc) got++;
            n++;
        end
        if (got < 10000) begin
            n_vec++;
            n_err++;
            $display("FAIL soak_budget: accepted %0d of 10000", got);
        end
        in_valid_d  = 1'b0;
        ovf_clr_d   = 1'b0;
        out_ready_d = 1'b1;
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
